// File: rtl/hwpe_stream_zero_sink.sv
// ============================================================================
// Module   : hwpe_stream_zero_sink
// Brief    : Terminating sink of the zero (shadow) stream; mirrors ready back to
//            the zero network and flags valid/strb divergence from the normal stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hwpe_stream_zero_sink #(
  parameter int unsigned CHECK_STRB = 1,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned STRB_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  // normal stream, monitored at the consumer
  input  logic                  normal_valid_i,
  input  logic                  normal_ready_i,
  input  logic [STRB_WIDTH-1:0] normal_strb_i,
  // zero stream, terminated here
  input  logic                  zero_valid_i,
  input  logic [STRB_WIDTH-1:0] zero_strb_i,
  output logic                  zero_ready_o,
  // fault reporting
  output logic                  fault_pulse_o,
  output logic                  fault_detected_o,
  output logic [1:0]            fault_kind_o,
  output logic [CNT_WIDTH-1:0]  fault_count_o
);

  localparam logic C_CHECK_STRB = (CHECK_STRB != 0);

  logic                 w_mm_v;
  logic                 w_mm_s;
  logic                 w_mm;
  logic                 w_cnt_max;

  logic                 r_pulse;
  logic                 r_detected;
  logic [1:0]           r_kind;
  logic [CNT_WIDTH-1:0] r_count;

  // Ready must stay a pure wire so both networks advance on the same cycle.
  assign zero_ready_o = normal_ready_i;

  assign w_mm_v    = normal_valid_i != zero_valid_i;
  assign w_mm_s    = C_CHECK_STRB && normal_valid_i && zero_valid_i &&
                     (normal_strb_i != zero_strb_i);
  assign w_mm      = enable_i && (w_mm_v || w_mm_s);
  assign w_cnt_max = &r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pulse    <= 1'b0;
      r_detected <= 1'b0;
      r_kind     <= 2'b00;
      r_count    <= '0;
    end else if (clear_i) begin
      r_pulse    <= 1'b0;
      r_detected <= 1'b0;
      r_kind     <= 2'b00;
      r_count    <= '0;
    end else begin
      r_pulse <= w_mm;
      if (w_mm) begin
        r_detected <= 1'b1;
        // Only the first fault is classified; later ones leave the class frozen.
        if (!r_detected) begin
          r_kind <= {w_mm_s, w_mm_v};
        end
        if (!w_cnt_max) begin
          r_count <= r_count + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign fault_pulse_o    = r_pulse;
  assign fault_detected_o = r_detected;
  assign fault_kind_o     = r_kind;
  assign fault_count_o    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_hwpe_stream_zero_sink.sv
// ============================================================================
// Module   : tb_hwpe_stream_zero_sink
// Brief    : Randomized self-checking bench for hwpe_stream_zero_sink with a
//            behavioural fault model for three parameter configurations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hwpe_stream_zero_sink;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       en  = 1'b1;
  logic       nv  = 1'b0;
  logic       zv  = 1'b0;
  logic       nr  = 1'b0;
  logic [3:0] ns  = 4'h0;
  logic [3:0] zs  = 4'h0;

  logic       zr    [3];
  logic       pulse [3];
  logic       det   [3];
  logic [1:0] kind  [3];
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [2:0] cnt2;

  int checks = 0;
  int errors = 0;

  // instance 0: defaults; instance 1: valid-only checking; instance 2: 3-bit counter
  hwpe_stream_zero_sink #(.CHECK_STRB(1), .CNT_WIDTH(8), .STRB_WIDTH(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .enable_i(en),
    .normal_valid_i(nv), .normal_ready_i(nr), .normal_strb_i(ns),
    .zero_valid_i(zv), .zero_strb_i(zs), .zero_ready_o(zr[0]),
    .fault_pulse_o(pulse[0]), .fault_detected_o(det[0]),
    .fault_kind_o(kind[0]), .fault_count_o(cnt0));

  hwpe_stream_zero_sink #(.CHECK_STRB(0), .CNT_WIDTH(8), .STRB_WIDTH(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .enable_i(en),
    .normal_valid_i(nv), .normal_ready_i(nr), .normal_strb_i(ns),
    .zero_valid_i(zv), .zero_strb_i(zs), .zero_ready_o(zr[1]),
    .fault_pulse_o(pulse[1]), .fault_detected_o(det[1]),
    .fault_kind_o(kind[1]), .fault_count_o(cnt1));

  hwpe_stream_zero_sink #(.CHECK_STRB(1), .CNT_WIDTH(3), .STRB_WIDTH(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .enable_i(en),
    .normal_valid_i(nv), .normal_ready_i(nr), .normal_strb_i(ns),
    .zero_valid_i(zv), .zero_strb_i(zs), .zero_ready_o(zr[2]),
    .fault_pulse_o(pulse[2]), .fault_detected_o(det[2]),
    .fault_kind_o(kind[2]), .fault_count_o(cnt2));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_chk_strb [3] = '{1'b1, 1'b0, 1'b1};
  int m_max      [3] = '{255, 255, 7};
  int m_pulse    [3] = '{0, 0, 0};
  int m_det      [3] = '{0, 0, 0};
  int m_kind     [3] = '{0, 0, 0};
  int m_cnt      [3] = '{0, 0, 0};

  always @(posedge clk or posedge rst) begin
    for (int c = 0; c < 3; c++) begin
      bit valid_diff;
      bit strb_diff;
      bit fault;
      valid_diff = (nv != zv);
      strb_diff  = m_chk_strb[c] && nv && zv && (ns != zs);
      fault      = en && (valid_diff || strb_diff);
      if (rst || clr) begin
        m_pulse[c] = 0; m_det[c] = 0; m_kind[c] = 0; m_cnt[c] = 0;
      end else begin
        m_pulse[c] = fault ? 1 : 0;
        if (fault) begin
          if (m_det[c] == 0) m_kind[c] = strb_diff ? 2 : 1;
          m_det[c] = 1;
          if (m_cnt[c] < m_max[c]) m_cnt[c] = m_cnt[c] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int get_cnt(input int c);
    case (c)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  // per-cycle comparison against the model
  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ready[%0d]", c), int'(zr[c]), int'(nr));
      chk($sformatf("pulse[%0d]", c), int'(pulse[c]), m_pulse[c]);
      chk($sformatf("detected[%0d]", c), int'(det[c]), m_det[c]);
      chk($sformatf("kind[%0d]", c), int'(kind[c]), m_kind[c]);
      chk($sformatf("count[%0d]", c), get_cnt(c), m_cnt[c]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lockstep();
    nv = 1'($urandom_range(0, 1));
    zv = nv;
    ns = 4'($urandom);
    zs = ns;
    nr = 1'($urandom_range(0, 1));
  endtask

  task automatic do_clear();
    lockstep();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    // reset
    lockstep();
    step();
    step();
    chk("reset_pulse", int'(pulse[0]), 0);
    chk("reset_detected", int'(det[0]), 0);
    chk("reset_kind", int'(kind[0]), 0);
    chk("reset_count", int'(cnt0), 0);
    rst = 1'b0;

    // lockstep traffic with backpressure
    for (int k = 0; k < 100; k++) begin
      lockstep();
      step();
    end
    chk("lockstep_detected", int'(det[0]), 0);
    chk("lockstep_count", int'(cnt0), 0);

    // single valid fault in cycle 10
    do_clear();
    for (int k = 0; k < 15; k++) begin
      lockstep();
      nv = 1'b1;
      zv = (k != 10);
      step();
      if (k == 10) begin
        chk("vfault_pulse", int'(pulse[0]), 1);
        chk("vfault_kind", int'(kind[0]), 1);
        chk("vfault_count", int'(cnt0), 1);
      end
      if (k == 11) begin
        chk("vfault_pulse_gone", int'(pulse[0]), 0);
        chk("vfault_detected", int'(det[0]), 1);
      end
    end

    // strb fault in cycle 5, valid fault in cycle 8
    do_clear();
    for (int k = 0; k < 12; k++) begin
      lockstep();
      nv = 1'b1;
      zv = 1'b1;
      if (k == 5) begin ns = 4'hF; zs = 4'hE; end
      if (k == 8) zv = 1'b0;
      step();
    end
    chk("strb_kind", int'(kind[0]), 2);
    chk("strb_count", int'(cnt0), 2);
    chk("nostrb_kind", int'(kind[1]), 1);
    chk("nostrb_count", int'(cnt1), 1);

    // saturation of the 3-bit counter
    do_clear();
    for (int k = 0; k < 10; k++) begin
      lockstep();
      nv = 1'b1;
      zv = 1'b0;
      step();
      chk("sat_count", int'(cnt2), (k + 1 < 7) ? k + 1 : 7);
      chk("sat_pulse", int'(pulse[2]), 1);
    end
    lockstep();
    step();
    chk("sat_count_hold", int'(cnt2), 7);
    chk("wide_count", int'(cnt0), 10);

    // clear beats a simultaneous mismatch
    lockstep();
    nv = 1'b1; zv = 1'b0;
    step();
    nv = 1'b1; zv = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_pulse", int'(pulse[0]), 0);
    chk("clr_detected", int'(det[0]), 0);
    chk("clr_kind", int'(kind[0]), 0);
    chk("clr_count", int'(cnt0), 0);

    // disabled checker ignores mismatches
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      lockstep();
      nv = 1'b0; zv = 1'b1;
      step();
    end
    chk("dis_detected", int'(det[0]), 0);
    chk("dis_count", int'(cnt0), 0);
    en = 1'b1;

    // random mixed traffic with injected faults, enable and clear
    for (int k = 0; k < 400; k++) begin
      lockstep();
      if ($urandom_range(0, 9) == 0) zv = ~nv;
      if ($urandom_range(0, 9) == 0) zs = ns ^ 4'($urandom_range(1, 15));
      en  = ($urandom_range(0, 4) != 0);
      clr = ($urandom_range(0, 29) == 0);
      step();
    end
    clr = 1'b0;
    en  = 1'b1;

    // asynchronous reset in the middle of a fault burst
    do_clear();
    for (int k = 0; k < 4; k++) begin
      lockstep();
      nv = 1'b1; zv = 1'b0;
      step();
    end
    chk("pre_rst_count", int'(cnt0), 4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pulse", int'(pulse[0]), 0);
    chk("arst_detected", int'(det[0]), 0);
    chk("arst_kind", int'(kind[0]), 0);
    chk("arst_count", int'(cnt0), 0);
    nr = ~nr;
    #1;
    chk("arst_ready", int'(zr[0]), int'(nr));
    step();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      lockstep();
      if ($urandom_range(0, 3) == 0) zv = ~nv;
      step();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hwpe_stream_zero_sink.md
# hwpe_stream_zero_sink

Terminating end of the zero (shadow) stream network used for low-area fault detection on HWPE streams. It sits beside the consumer of a normal stream and accepts the matching data-less zero stream. It returns the consumer's `ready` to the zero network so that both networks stay in lockstep. It checks every cycle that `valid` and `strb` of the zero stream equal those of the normal stream, and reports faults through registered pulse, sticky, classification and count outputs.

## Interface
- `CHECK_STRB`, default 1: 1 = compare `strb` in cycles where both streams are valid; 0 = compare `valid` only.
- `CNT_WIDTH`, default 8: width of the saturating fault counter.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `clear_i`  in  1  synchronous clear of all fault state.
- `enable_i`  in  1  checker enable; when 0, mismatches are ignored.
- `normal_i`  monitor  `hwpe_stream_intf_stream`  the normal stream at the consumer; observed only, never driven.
- `zero_i`  sink  `hwpe_stream_intf_stream`  the zero stream; its `data` is ignored; `ready` is driven by this block.
- `fault_pulse_o`  out  1  one-cycle pulse per mismatching cycle.
- `fault_detected_o`  out  1  sticky fault flag.
- `fault_kind_o`  out  2  class of the first fault since reset or clear: bit0 = valid mismatch, bit1 = strb mismatch.
- `fault_count_o`  out  `CNT_WIDTH`  number of mismatching cycles, saturating.

## Operation
- `zero_i.ready = normal_i.ready`, purely combinational.
  - Independent of `enable_i`, `clear_i` and reset state.
  - Must never be registered, or lockstep is lost.
- Combinational mismatch terms:
  - `mm_v = normal_i.valid != zero_i.valid`.
  - `mm_s = CHECK_STRB && normal_i.valid && zero_i.valid && (normal_i.strb != zero_i.strb)`.
  - `mm = enable_i && (mm_v || mm_s)`.
- `strb` is not compared when either stream is not valid.
- `data` on either stream is never read.
- Registered state is updated at each rising edge, in priority order:
  1. `rst_i`: all state is 0 (asynchronous).
  2. `clear_i`: `fault_pulse_o`, `fault_detected_o`, `fault_kind_o` and `fault_count_o` all become 0. A mismatch in the clear cycle is discarded.
  3. Otherwise:
     - `fault_pulse_o <= mm`.
     - If `mm`: `fault_detected_o <= 1`.
     - If `mm` and `fault_detected_o == 0`: `fault_kind_o <= {mm_s, mm_v}`.
     - If `mm` and the count is below `2**CNT_WIDTH-1`: `fault_count_o` increments by 1. At the maximum it holds.
- `fault_kind_o` is frozen after the first fault until reset or clear. Later faults of another class do not change it.
- `mm_v` and `mm_s` are mutually exclusive in a given cycle, so `fault_kind_o` is one-hot or zero.
- Handshakes are not counted. Only per-cycle equality of `valid`/`strb` is checked, so a stalled cycle with both streams valid and `ready=0` is still checked.

## Timing
- Reset values: `fault_pulse_o=0`, `fault_detected_o=0`, `fault_kind_o=2'b00`, `fault_count_o=0`.
- `zero_i.ready` follows `normal_i.ready` combinationally, including during reset.
- Latency: a mismatch in cycle N gives `fault_pulse_o=1` in cycle N+1. `fault_detected_o`, `fault_kind_o` and the count update at the same edge.
- Consecutive mismatching cycles give a continuously high `fault_pulse_o`, and the count increases by 1 per cycle.
- Clear and mismatch in the same cycle: clear wins, and all outputs are 0 in the next cycle.
- Reset asserted mid-operation: all outputs drop to 0 immediately without waiting for a clock edge. Checking resumes at the first edge after deassertion.
- `enable_i` is sampled in the same cycle as the mismatch. If `enable_i` is dropped, an already-registered pulse still appears.

## Test plan
- Lockstep traffic: 100 random transfers with identical `valid`/`strb` and random `normal_i.ready` backpressure.
  - `zero_i.ready` always equals `normal_i.ready`.
  - No pulse; `fault_detected_o=0`; `fault_count_o=0`.
- Injected valid fault: `zero_i.valid=0` while `normal_i.valid=1` in cycle 10 only.
  - `fault_pulse_o=1` in cycle 11 only.
  - `fault_detected_o=1` from cycle 11; `fault_kind_o=2'b01`; `fault_count_o=1`.
- Strb fault followed by valid fault: strb `4'hF` vs `4'hE` in cycle 5, then a valid mismatch in cycle 8.
  - `fault_kind_o=2'b10` and stays so; `fault_count_o=2`.
  - With `CHECK_STRB=0`: only the cycle-8 fault is seen, `fault_kind_o=2'b01`, `fault_count_o=1`.
- Saturation with `CNT_WIDTH=3`: 10 consecutive valid mismatches.
  - `fault_count_o` goes 1..7 and stays 7; `fault_pulse_o` is high for 10 cycles.
- Clear and enable:
  - `clear_i` with a simultaneous mismatch: next cycle all outputs are 0.
  - `enable_i=0` over 5 mismatching cycles: no outputs change.
- Asynchronous reset mid-fault: assert `rst_i` between clock edges while `fault_count_o=4`.
  - All outputs are 0 before the next edge.
  - `zero_i.ready` still tracks `normal_i.ready`.
